imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time controller for the CPU's 32-bit instruction memory. It receives a program image as a byte stream from the UART receiver, packs it big-endian into words and writes them to the instruction RAM write port. While a load is in progress it holds the CPU and substitutes NOPs on the fetch path. It sits between the UART RX, the instruction RAM and the CPU fetch port, replacing the fixed-image ROM when a reloadable program store is needed.

## Interface

Parameters:
- ADDR_BITS, 6, word-address width; memory depth 2^ADDR_BITS words; legal range 1..8.
- TIMEOUT, 1_000_000, idle clocks allowed between bytes inside a session before abort.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- load_req  in  1  start-session pulse.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- cpu_addr  in  32  CPU fetch byte address.
- cpu_data  out  32  instruction returned to the CPU.
- mem_raddr  out  ADDR_BITS  RAM read address; always cpu_addr[ADDR_BITS+1:2].
- mem_rdata  in  32  RAM combinational read data.
- mem_we  out  1  RAM write enable, one-cycle pulse.
- mem_waddr  out  ADDR_BITS  RAM write word address.
- mem_wdata  out  32  RAM write data.
- cpu_hold  out  1  high while a session is active; the CPU stalls or holds its PC.
- load_done  out  1  one-cycle pulse on successful completion.
- load_err  out  1  one-cycle pulse on abort.
- word_count  out  ADDR_BITS+1  number of words written in the current or last session.

## Operation

- States: IDLE, COUNT, DATA, DONE.
- **IDLE**
  - load_req=1 → COUNT; clear word_count, byte index and write address.
  - rx_valid is ignored in IDLE.
- **COUNT**
  - The first byte accepted is the word count N.
  - N=0 encodes 256 words.
  - If N > 2^ADDR_BITS: load_err pulse, then → IDLE; nothing is written.
  - Otherwise latch N and → DATA.
- **DATA**
  - Bytes are shifted into a 32-bit assembly register, MSB first. Byte 0 is bits [31:24].
  - A 2-bit byte index counts accepted bytes.
  - On the 4th byte, the next cycle carries mem_we=1, mem_waddr = current address and mem_wdata = the assembled word.
  - In that same cycle the address increments and word_count increments.
  - When word_count reaches N: → DONE.
- **DONE**
  - Lasts one cycle: load_done=1, cpu_hold still 1.
  - Then → IDLE.
- **Timeout**
  - In COUNT or DATA, an idle counter resets on every rx_valid and increments otherwise.
  - When it reaches TIMEOUT: load_err pulse, → IDLE.
  - Words already written stay written; word_count holds its value.
- **Fetch path**
  - cpu_data = mem_rdata when cpu_hold=0.
  - cpu_data = 32'h0000_0000 (NOP) when cpu_hold=1.
- cpu_hold = (state != IDLE).
- load_req while not in IDLE is ignored.
- Address wrap cannot occur, because N ≤ depth is enforced.

## Timing

- Reset values: state IDLE, cpu_hold 0, mem_we 0, mem_waddr 0, mem_wdata 0, load_done 0, load_err 0, word_count 0, idle counter 0.
- reset wins over every other input in the same cycle.
- Reset mid-session: return to IDLE next edge; no further writes; no done/err pulse.
- load_req at edge t → cpu_hold=1 from t+1.
- 4th byte of a word accepted at edge t → mem_we high during cycle t+1.
- rx_valid in cycle t+1 is accepted normally; there are no dead cycles.
- Last write at cycle t+1 → DONE at t+2, load_done=1 at t+2, cpu_hold=0 from t+3.
- The fetch path is combinational: zero added latency.
- Timeout abort: load_err asserts in the cycle after the counter hits TIMEOUT; cpu_hold falls the same cycle.
- rx_valid and timeout in the same cycle: the byte wins and the counter clears.

## Structure

- Shared package mips_pkg holds:
  - the state encoding as a localparam enum;
  - the NOP constant 32'h0000_0000;
  - byte-order constants.
- One sub-module, idle_timer:
  - inputs clear, enable; output expired;
  - width $clog2(TIMEOUT+1).
- The word assembler and write pulse stay in the top module.

## Test plan

- **Load 3 words:** load_req, then bytes 03, 20 08 00 05, 3C 01 10 00, AC 01 00 00 → writes at 0/1/2 = 0x20080005, 0x3C011000, 0xAC010000; one load_done; word_count=3; cpu_hold low afterwards.
- **Fetch during load:** cpu_hold=1, cpu_addr=0x4 → cpu_data=0x00000000. After done, cpu_addr=0x4 → cpu_data = RAM word 1.
- **Oversized count:** with ADDR_BITS=6, count byte 0x41 → load_err pulse, mem_we never asserted, IDLE.
- **Timeout:** with TIMEOUT=16, count 02 then 5 bytes then silence → one write at address 0, load_err 17 cycles after the last byte, word_count=1.
- **Back-to-back bytes:** rx_valid on consecutive cycles for a full word plus the next byte → the write pulse overlaps the accepted byte; both words are correct.
- **Reset mid-DATA:** after 6 bytes → cpu_hold=0 next cycle, no further mem_we, no load_done or load_err, word_count=0.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared types and constants for the instruction-memory loader
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package mips_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DATA  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam logic [31:0] c_NOP = 32'h0000_0000;

   // Big-endian packing: the first byte of a word lands in bits [31:24]
   localparam int unsigned c_BYTE_W         = 8;
   localparam int unsigned c_BYTES_PER_WORD = 4;
   localparam logic [1:0]  c_LAST_BYTE      = 2'(c_BYTES_PER_WORD - 1);

   // A count byte of zero stands for 256 words
   function automatic logic [8:0] decode_count(input logic [c_BYTE_W-1:0] b);
      return (b == '0) ? 9'd256 : {1'b0, b};
   endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_idle_timer.sv
// ============================================================================
// idle_timer : saturating idle counter, flags expiry when it reaches TIMEOUT
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module idle_timer #(
   parameter int unsigned TIMEOUT = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned W = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0] c_LIMIT = W'(TIMEOUT);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_q <= '0;
      end else if (enable && (count_q != c_LIMIT)) begin
         count_q <= count_q + W'(1);
      end
   end

   assign expired = enable && (count_q == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : loads a UART byte stream into instruction RAM, big-endian,
//               holding the CPU and feeding it NOPs while a session runs
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module imem_loader
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 6,
   parameter int unsigned TIMEOUT   = 1_000_000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_req,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   input  logic [31:0]          cpu_addr,
   output logic [31:0]          cpu_data,
   output logic [ADDR_BITS-1:0] mem_raddr,
   input  logic [31:0]          mem_rdata,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_waddr,
   output logic [31:0]          mem_wdata,
   output logic                 cpu_hold,
   output logic                 load_done,
   output logic                 load_err,
   output logic [ADDR_BITS:0]   word_count
);

   localparam logic [9:0] c_DEPTH = 10'(1) << ADDR_BITS;

   state_e               state_q;
   logic [8:0]           n_q;
   logic [1:0]           byte_idx_q;
   logic [31:0]          asm_q;
   logic [ADDR_BITS-1:0] waddr_q;
   logic [ADDR_BITS:0]   word_count_q;
   logic                 mem_we_q;
   logic [ADDR_BITS-1:0] mem_waddr_q;
   logic [31:0]          mem_wdata_q;
   logic                 load_done_q;
   logic                 load_err_q;

   logic [8:0]           count_d;
   logic [31:0]          asm_d;
   logic                 w_active;
   logic                 w_expired;
   logic                 w_unused_addr;

   assign count_d  = decode_count(rx_data);
   assign asm_d    = {asm_q[23:0], rx_data};
   assign w_active = (state_q == S_COUNT) || (state_q == S_DATA);

   idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (rx_valid || !w_active),
      .enable  (w_active),
      .expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         n_q          <= '0;
         byte_idx_q   <= '0;
         asm_q        <= '0;
         waddr_q      <= '0;
         word_count_q <= '0;
         mem_we_q     <= 1'b0;
         mem_waddr_q  <= '0;
         mem_wdata_q  <= '0;
         load_done_q  <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         mem_we_q    <= 1'b0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (load_req) begin
                  state_q      <= S_COUNT;
                  word_count_q <= '0;
                  byte_idx_q   <= '0;
                  waddr_q      <= '0;
               end
            end
            S_COUNT: begin
               if (rx_valid) begin
                  if ({1'b0, count_d} > c_DEPTH) begin
                     load_err_q <= 1'b1;
                     state_q    <= S_IDLE;
                  end else begin
                     n_q     <= count_d;
                     state_q <= S_DATA;
                  end
               end else if (w_expired) begin
                  load_err_q <= 1'b1;
                  state_q    <= S_IDLE;
               end
            end
            S_DATA: begin
               // word_count already reflects a write issued on the previous edge
               if (9'(word_count_q) == n_q) begin
                  load_done_q <= 1'b1;
                  state_q     <= S_DONE;
               end else if (rx_valid) begin
                  asm_q      <= asm_d;
                  byte_idx_q <= byte_idx_q + 2'd1;
                  if (byte_idx_q == c_LAST_BYTE) begin
                     mem_we_q     <= 1'b1;
                     mem_waddr_q  <= waddr_q;
                     mem_wdata_q  <= asm_d;
                     waddr_q      <= waddr_q + ADDR_BITS'(1);
                     word_count_q <= word_count_q + (ADDR_BITS + 1)'(1);
                  end
               end else if (w_expired) begin
                  load_err_q <= 1'b1;
                  state_q    <= S_IDLE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cpu_hold   = (state_q != S_IDLE);
   assign cpu_data   = cpu_hold ? c_NOP : mem_rdata;
   assign mem_raddr  = cpu_addr[ADDR_BITS+1:2];
   assign mem_we     = mem_we_q;
   assign mem_waddr  = mem_waddr_q;
   assign mem_wdata  = mem_wdata_q;
   assign load_done  = load_done_q;
   assign load_err   = load_err_q;
   assign word_count = word_count_q;

   assign w_unused_addr = ^{cpu_addr[31:ADDR_BITS+2], cpu_addr[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader : directed self-checking bench for imem_loader
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

   localparam int unsigned ADDR_BITS = 6;
   localparam int unsigned TIMEOUT   = 16;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 load_req = 1'b0;
   logic                 rx_valid = 1'b0;
   logic [7:0]           rx_data = 8'h00;
   logic [31:0]          cpu_addr = 32'h0;
   logic [31:0]          cpu_data;
   logic [ADDR_BITS-1:0] mem_raddr;
   logic [31:0]          mem_rdata;
   logic                 mem_we;
   logic [ADDR_BITS-1:0] mem_waddr;
   logic [31:0]          mem_wdata;
   logic                 cpu_hold;
   logic                 load_done;
   logic                 load_err;
   logic [ADDR_BITS:0]   word_count;

   logic [31:0] ram [0:(1<<ADDR_BITS)-1];
   int          we_cnt = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          checks = 0;
   int          failures = 0;
   int          snap_we, snap_done, snap_err;

   imem_loader #(
      .ADDR_BITS (ADDR_BITS),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load_req   (load_req),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .cpu_addr   (cpu_addr),
      .cpu_data   (cpu_data),
      .mem_raddr  (mem_raddr),
      .mem_rdata  (mem_rdata),
      .mem_we     (mem_we),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_err   (load_err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   assign mem_rdata = ram[mem_raddr];

   always @(posedge clk) begin
      if (mem_we) begin
         ram[mem_waddr] <= mem_wdata;
         we_cnt         <= we_cnt + 1;
      end
      if (load_done) done_cnt <= done_cnt + 1;
      if (load_err)  err_cnt  <= err_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic start();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      check("rst_hold",  32'(cpu_hold),   32'd0);
      check("rst_we",    32'(mem_we),     32'd0);
      check("rst_waddr", 32'(mem_waddr),  32'd0);
      check("rst_wdata", mem_wdata,       32'd0);
      check("rst_done",  32'(load_done),  32'd0);
      check("rst_err",   32'(load_err),   32'd0);
      check("rst_wc",    32'(word_count), 32'd0);
      reset = 1'b0;
      tick();

      // Bytes in IDLE are ignored
      send(8'h01);
      check("idle_rx_hold", 32'(cpu_hold), 32'd0);

      // Load 3 words, one idle cycle between bytes
      start();
      check("t1_hold_on", 32'(cpu_hold), 32'd1);
      cpu_addr = 32'h4;
      #1;
      check("t1_fetch_nop", cpu_data, 32'h0000_0000);
      send(8'h03); tick();
      send(8'h20); tick();
      send(8'h08); tick();
      send(8'h00); tick();
      send(8'h05);
      check("t1_w0_we",    32'(mem_we),     32'd1);
      check("t1_w0_addr",  32'(mem_waddr),  32'd0);
      check("t1_w0_data",  mem_wdata,       32'h2008_0005);
      check("t1_w0_wc",    32'(word_count), 32'd1);
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      check("t1_w0_we_off", 32'(mem_we),    32'd0);
      check("t1_ldreq_ign", 32'(word_count), 32'd1);
      send(8'h3C); tick();
      send(8'h01); tick();
      send(8'h10); tick();
      send(8'h00);
      check("t1_w1_addr",  32'(mem_waddr),  32'd1);
      check("t1_w1_data",  mem_wdata,       32'h3C01_1000);
      tick();
      send(8'hAC); tick();
      send(8'h01); tick();
      send(8'h00); tick();
      send(8'h00);
      check("t1_w2_we",    32'(mem_we),     32'd1);
      check("t1_w2_addr",  32'(mem_waddr),  32'd2);
      check("t1_w2_data",  mem_wdata,       32'hAC01_0000);
      check("t1_w2_wc",    32'(word_count), 32'd3);
      check("t1_pre_done", 32'(load_done),  32'd0);
      tick();
      check("t1_done",      32'(load_done), 32'd1);
      check("t1_done_hold", 32'(cpu_hold),  32'd1);
      tick();
      check("t1_hold_off",  32'(cpu_hold),  32'd0);
      check("t1_done_off",  32'(load_done), 32'd0);
      check("t1_fetch_w1",  cpu_data,       32'h3C01_1000);
      cpu_addr = 32'h0;
      #1;
      check("t1_fetch_w0",  cpu_data,       32'h2008_0005);
      cpu_addr = 32'h8;
      #1;
      check("t1_fetch_w2",  cpu_data,       32'hAC01_0000);
      check("t1_we_cnt",    32'(we_cnt),    32'd3);
      check("t1_done_cnt",  32'(done_cnt),  32'd1);
      check("t1_err_cnt",   32'(err_cnt),   32'd0);

      // Oversized count 0x41 > 64
      start();
      send(8'h41);
      check("t2_err",     32'(load_err),   32'd1);
      check("t2_hold",    32'(cpu_hold),   32'd0);
      check("t2_wc",      32'(word_count), 32'd0);
      tick();
      check("t2_err_off", 32'(load_err),   32'd0);
      check("t2_no_we",   32'(we_cnt),     32'd3);

      // Count byte 0 means 256, also too large
      start();
      send(8'h00);
      check("t2b_err",  32'(load_err), 32'd1);
      check("t2b_hold", 32'(cpu_hold), 32'd0);
      tick();

      // Timeout: count 2, five back-to-back bytes, then silence
      start();
      send(8'h02);
      send(8'h11);
      send(8'h22);
      send(8'h33);
      send(8'h44);
      check("t3_we",   32'(mem_we),    32'd1);
      check("t3_addr", 32'(mem_waddr), 32'd0);
      check("t3_data", mem_wdata,      32'h1122_3344);
      send(8'h55);
      repeat (16) tick();
      check("t3_err_early",  32'(load_err), 32'd0);
      check("t3_hold_early", 32'(cpu_hold), 32'd1);
      tick();
      check("t3_err",  32'(load_err),   32'd1);
      check("t3_hold", 32'(cpu_hold),   32'd0);
      check("t3_wc",   32'(word_count), 32'd1);
      tick();
      check("t3_we_cnt",  32'(we_cnt),  32'd4);
      check("t3_err_cnt", 32'(err_cnt), 32'd3);

      // Back-to-back bytes across a word boundary
      start();
      send(8'h02);
      send(8'hDE);
      send(8'hAD);
      send(8'hBE);
      send(8'hEF);
      check("t4_w0_data", mem_wdata, 32'hDEAD_BEEF);
      send(8'h01);
      check("t4_w0_we_off", 32'(mem_we), 32'd0);
      send(8'h23);
      send(8'h45);
      send(8'h67);
      check("t4_w1_we",   32'(mem_we),     32'd1);
      check("t4_w1_addr", 32'(mem_waddr),  32'd1);
      check("t4_w1_data", mem_wdata,       32'h0123_4567);
      check("t4_wc",      32'(word_count), 32'd2);
      tick();
      check("t4_done", 32'(load_done), 32'd1);
      tick();
      check("t4_hold_off", 32'(cpu_hold), 32'd0);
      cpu_addr = 32'h0;
      #1;
      check("t4_fetch_w0", cpu_data, 32'hDEAD_BEEF);
      cpu_addr = 32'h4;
      #1;
      check("t4_fetch_w1", cpu_data, 32'h0123_4567);

      // Count of exactly the depth is accepted; then reset mid-DATA
      start();
      send(8'h40);
      check("t5_depth_ok",  32'(load_err), 32'd0);
      check("t5_depth_hold", 32'(cpu_hold), 32'd1);
      send(8'hA1); tick();
      send(8'hA2); tick();
      send(8'hA3); tick();
      send(8'hA4); tick();
      send(8'hB1); tick();
      send(8'hB2);
      snap_we   = we_cnt;
      snap_done = done_cnt;
      snap_err  = err_cnt;
      reset = 1'b1;
      tick();
      check("t5_hold", 32'(cpu_hold),   32'd0);
      check("t5_we",   32'(mem_we),     32'd0);
      check("t5_wc",   32'(word_count), 32'd0);
      reset = 1'b0;
      send(8'hB3);
      send(8'hB4);
      repeat (3) tick();
      check("t5_no_we",   32'(we_cnt),   32'(snap_we));
      check("t5_no_done", 32'(done_cnt), 32'(snap_done));
      check("t5_no_err",  32'(err_cnt),  32'(snap_err));
      check("t5_idle",    32'(cpu_hold), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
